// File: rtl/dcache_victim_buffer.sv
// Fully-associative victim buffer that sits beside the dcache eviction path.
// Evicted lines are parked here. A dcache miss lookup that hits pulls the line
// back out, so a line never lives in both places. Dirty lines that are pushed
// out of the buffer, or drained by a flush, go to memory over a req/ack
// writeback port.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_IDLE       | serving lookups and evictions
// ST_EVICT_WB   | writing back the dirty fifo_ptr entry so an eviction can land
// ST_FLUSH_SCAN | looking for the lowest valid+dirty entry to drain
// ST_FLUSH_WB   | writing back the entry picked by the scan
// ST_FLUSH_DONE | flush complete, flush_done_o pulses for one cycle
module dcache_victim_buffer #(
  parameter int VC_ENTRIES  = 4,
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_req_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_ready_o,
  output logic                  lookup_valid_o,
  output logic                  victim_hit_o,
  output logic [LINE_WIDTH-1:0] victim_data_o,
  output logic                  victim_dirty_o,
  input  logic                  evict_req_i,
  input  logic [ADDR_WIDTH-1:0] evict_addr_i,
  input  logic [LINE_WIDTH-1:0] evict_data_i,
  input  logic                  evict_dirty_i,
  output logic                  evict_ready_o,
  output logic                  wb_req_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [LINE_WIDTH-1:0] wb_data_o,
  input  logic                  wb_ack_i,
  input  logic                  flush_i,
  output logic                  flush_done_o
);

  localparam int KEY_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int IDX_W = $clog2(VC_ENTRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVICT_WB,
    ST_FLUSH_SCAN,
    ST_FLUSH_WB,
    ST_FLUSH_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [VC_ENTRIES-1:0]   valid_q, valid_d;
  logic [VC_ENTRIES-1:0]   dirty_q, dirty_d;
  logic [IDX_W-1:0]        fifo_ptr_q, fifo_ptr_d;
  logic [IDX_W-1:0]        wb_idx_q, wb_idx_d;
  logic [KEY_W-1:0]        key_q  [VC_ENTRIES];
  logic [LINE_WIDTH-1:0]   data_q [VC_ENTRIES];

  logic                    resp_valid_q, resp_hit_q, resp_dirty_q;
  logic [LINE_WIDTH-1:0]   resp_data_q;

  logic [KEY_W-1:0]        lookup_key, evict_key;
  logic                    lk_hit;
  logic [IDX_W-1:0]        lk_idx;
  logic                    ev_match;
  logic [IDX_W-1:0]        ev_match_idx;
  logic                    inv_found;
  logic [IDX_W-1:0]        inv_idx;
  logic                    fl_found;
  logic [IDX_W-1:0]        fl_idx;
  logic [IDX_W-1:0]        ev_idx;
  logic                    ev_case3;
  logic                    evict_blocked;

  logic                    lookup_ready, evict_ready, wb_req, flush_done;
  logic                    lookup_fire, evict_we;

  // Offset bits only select a byte within a line; the buffer works on line keys.
  logic                    unused_offset_bits;
  assign unused_offset_bits = ^{lookup_addr_i[OFFSET_BITS-1:0], evict_addr_i[OFFSET_BITS-1:0]};

  assign lookup_key = lookup_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
  assign evict_key  = evict_addr_i[ADDR_WIDTH-1:OFFSET_BITS];

  // Associative search over pre-edge contents; descending loop so the lowest index wins.
  always_comb begin
    lk_hit       = 1'b0;
    lk_idx       = '0;
    ev_match     = 1'b0;
    ev_match_idx = '0;
    inv_found    = 1'b0;
    inv_idx      = '0;
    fl_found     = 1'b0;
    fl_idx       = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == lookup_key)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && (key_q[i] == evict_key)) begin
        ev_match     = 1'b1;
        ev_match_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
      if (valid_q[i] && dirty_q[i]) begin
        fl_found = 1'b1;
        fl_idx   = IDX_W'(i);
      end
    end
  end

  // Allocation target: same key, then a free slot, then the oldest allocation.
  always_comb begin
    ev_case3 = 1'b0;
    if (ev_match) begin
      ev_idx = ev_match_idx;
    end else if (inv_found) begin
      ev_idx = inv_idx;
    end else begin
      ev_idx   = fifo_ptr_q;
      ev_case3 = 1'b1;
    end
    evict_blocked = ev_case3 && dirty_q[fifo_ptr_q];
  end

  // Next-state, handshake outputs and valid/dirty/fifo_ptr updates.
  always_comb begin
    state_d      = state_q;
    wb_idx_d     = wb_idx_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    fifo_ptr_d   = fifo_ptr_q;
    lookup_ready = 1'b0;
    evict_ready  = 1'b0;
    wb_req       = 1'b0;
    flush_done   = 1'b0;
    lookup_fire  = 1'b0;
    evict_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lookup_ready = 1'b1;
        evict_ready  = !flush_i && !evict_blocked;
        lookup_fire  = lookup_req_i;
        evict_we     = evict_req_i && evict_ready;
        // Lookup hit invalidates first so a same-slot insert below overrides it.
        if (lookup_fire && lk_hit) begin
          valid_d[lk_idx] = 1'b0;
          dirty_d[lk_idx] = 1'b0;
        end
        if (evict_we) begin
          valid_d[ev_idx] = 1'b1;
          dirty_d[ev_idx] = evict_dirty_i | (ev_match & dirty_q[ev_idx]);
          if (ev_case3) begin
            fifo_ptr_d = fifo_ptr_q + 1'b1;
          end
        end
        if (flush_i) begin
          state_d = ST_FLUSH_SCAN;
        end else if (evict_req_i && !evict_ready) begin
          wb_idx_d = fifo_ptr_q;
          state_d  = ST_EVICT_WB;
        end
      end
      ST_EVICT_WB: begin
        wb_req = 1'b1;
        if (wb_ack_i) begin
          dirty_d[wb_idx_q] = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      ST_FLUSH_SCAN: begin
        if (fl_found) begin
          wb_idx_d = fl_idx;
          state_d  = ST_FLUSH_WB;
        end else begin
          valid_d    = '0;
          dirty_d    = '0;
          fifo_ptr_d = '0;
          state_d    = ST_FLUSH_DONE;
        end
      end
      ST_FLUSH_WB: begin
        wb_req = 1'b1;
        if (wb_ack_i) begin
          dirty_d[wb_idx_q] = 1'b0;
          state_d           = ST_FLUSH_SCAN;
        end
      end
      ST_FLUSH_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and per-entry flags, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      fifo_ptr_q <= '0;
      wb_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      fifo_ptr_q <= fifo_ptr_d;
      wb_idx_q   <= wb_idx_d;
    end
  end

  // Line key and data storage; contents are meaningless while the valid bit is low.
  always_ff @(posedge clk) begin
    if (rst_n && evict_we) begin
      key_q[ev_idx]  <= evict_key;
      data_q[ev_idx] <= evict_data_i;
    end
  end

  // Registered lookup response, one cycle after the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_dirty_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= lookup_fire;
      resp_hit_q   <= lookup_fire && lk_hit;
      resp_dirty_q <= lookup_fire && lk_hit && dirty_q[lk_idx];
      resp_data_q  <= (lookup_fire && lk_hit) ? data_q[lk_idx] : '0;
    end
  end

  // Outputs forced low while reset is held so nothing leaks out during reset.
  assign lookup_ready_o = rst_n && lookup_ready;
  assign evict_ready_o  = rst_n && evict_ready;
  assign wb_req_o       = rst_n && wb_req;
  assign flush_done_o   = rst_n && flush_done;
  assign wb_addr_o      = wb_req_o ? {key_q[wb_idx_q], {OFFSET_BITS{1'b0}}} : '0;
  assign wb_data_o      = wb_req_o ? data_q[wb_idx_q] : '0;
  assign lookup_valid_o = rst_n && resp_valid_q;
  assign victim_hit_o   = rst_n && resp_hit_q;
  assign victim_dirty_o = rst_n && resp_dirty_q;
  assign victim_data_o  = rst_n ? resp_data_q : '0;

endmodule
